// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK reader.
// Contents:
//   - jstkPos bit indices (UP/DOWN/LEFT/RIGHT)
//   - reader FSM state encoding
//   - default axis thresholds and the reset centre value
//   - decode_pos(): threshold compare of the two 10-bit axes
package jstk_pkg;

    localparam int unsigned UP    = 3;
    localparam int unsigned DOWN  = 2;
    localparam int unsigned LEFT  = 1;
    localparam int unsigned RIGHT = 0;

    localparam logic [9:0] LOW_TH_DEF  = 10'd256;
    localparam logic [9:0] HIGH_TH_DEF = 10'd768;
    localparam logic [9:0] AXIS_CENTER = 10'd512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } jstk_state_t;

    // Strict compares: a value equal to a threshold sets no direction bit.
    // Up/down (and left/right) cannot both be set because LOW_TH < HIGH_TH.
    function automatic logic [3:0] decode_pos(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] low_th,
        input logic [9:0] high_th
    );
        logic [3:0] pos;
        pos        = 4'b0000;
        pos[UP]    = (y > high_th);
        pos[DOWN]  = (y < low_th);
        pos[RIGHT] = (x > high_th);
        pos[LEFT]  = (x < low_th);
        return pos;
    endfunction

endpackage

// File: rtl/jstk_reader_if.sv
// SPI bus between the joystick reader (master) and the PmodJSTK (slave).
// Signals:
//   ss   - chip select, active-low, driven by master
//   sclk - serial clock, idle low, driven by master
//   mosi - master-to-slave data (unused by the joystick, held at 0)
//   miso - slave-to-master data
interface jstk_reader_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (
        output ss,
        output sclk,
        output mosi,
        input  miso
    );

    modport slave (
        input  ss,
        input  sclk,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/jstk_reader_spi_byte_shifter.sv
// Mode-0 (CPOL=0, CPHA=0) single-byte SPI receive engine, MSB first.
// Ports:
//   clk, rst - system clock, asynchronous active-low reset
//   start    - begin one byte; sclk idles low for CLK_HALF cycles first
//   miso     - serial data in, sampled on each rising sclk edge
//   sclk     - serial clock out (registered)
//   data     - received byte (valid while done is high and afterwards)
//   done     - high during the cycle whose closing clk edge is the 8th
//              falling sclk edge, so the caller can move on at that edge
module spi_byte_shifter #(
    parameter int CLK_HALF = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miso,
    output logic       sclk,
    output logic [7:0] data,
    output logic       done
);

    logic        busy_r;
    logic        sclk_r;
    logic [31:0] half_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        half_end_s;

    assign half_end_s = busy_r && (half_cnt_r == 32'(CLK_HALF - 1));
    // Decoded from registers only; lets the sequencer leave SHIFT on the
    // very edge that drops sclk for the last time.
    assign done       = half_end_s && sclk_r && (bit_cnt_r == 3'd7);
    assign sclk       = sclk_r;
    assign data       = shift_r;

    // Half-period timer, sclk generation, sampling and bit counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r     <= 1'b0;
            sclk_r     <= 1'b0;
            half_cnt_r <= 32'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
        end else if (start) begin
            busy_r     <= 1'b1;
            sclk_r     <= 1'b0;
            half_cnt_r <= 32'd0;
            bit_cnt_r  <= 3'd0;
        end else if (half_end_s) begin
            half_cnt_r <= 32'd0;
            sclk_r     <= ~sclk_r;
            if (!sclk_r) begin
                // Rising edge: slave set miso up on the previous falling edge
                shift_r <= {shift_r[6:0], miso};
            end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    busy_r <= 1'b0;
                end else begin
                    busy_r <= 1'b1;
                end
            end
        end else if (busy_r) begin
            half_cnt_r <= half_cnt_r + 32'd1;
        end else begin
            half_cnt_r <= 32'd0;
        end
    end

endmodule

// File: rtl/jstk_reader.sv
// PmodJSTK poller: every poll period runs one 5-byte SPI read, decodes the
// X/Y axes and stick button, and updates level outputs for the game logic.
// Ports:
//   clk, rst        - system clock, asynchronous active-low reset
//   spi             - SPI master side (ss, sclk, mosi out; miso in)
//   jstkPos         - {up, down, left, right} level
//   jstkPress       - stick button level
//   jstkPressPulse  - one-cycle pulse on a 0->1 change of jstkPress
//   x_raw, y_raw    - last decoded axes
//   sample_valid    - one-cycle pulse when the outputs above update
module jstk_reader
    import jstk_pkg::*;
#(
    parameter int         CLK_HALF    = 100,
    parameter int         PRE_GAP     = 1500,
    parameter int         BYTE_GAP    = 1000,
    parameter int         POLL_CYCLES = 1_000_000,
    parameter logic [9:0] LOW_TH      = LOW_TH_DEF,
    parameter logic [9:0] HIGH_TH     = HIGH_TH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    jstk_reader_if.master    spi,
    output logic [3:0]       jstkPos,
    output logic             jstkPress,
    output logic             jstkPressPulse,
    output logic [9:0]       x_raw,
    output logic [9:0]       y_raw,
    output logic             sample_valid
);

    jstk_state_t state_r;
    jstk_state_t state_next_s;

    logic [31:0] cnt_r;
    logic [2:0]  idx_r;
    logic        start_s;
    logic        cnt_clr_s;
    logic        done_s;
    logic        sclk_s;
    logic [7:0]  data_s;

    logic [7:0]  x_lo_r;
    logic [1:0]  x_hi_r;
    logic [7:0]  y_lo_r;
    logic [1:0]  y_hi_r;
    logic        btn_r;
    logic [9:0]  x_new_s;
    logic [9:0]  y_new_s;

    logic        ss_r;
    logic [3:0]  pos_r;
    logic        press_r;
    logic        press_pulse_r;
    logic [9:0]  x_raw_r;
    logic [9:0]  y_raw_r;
    logic        sample_valid_r;

    spi_byte_shifter #(
        .CLK_HALF (CLK_HALF)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .miso  (spi.miso),
        .sclk  (sclk_s),
        .data  (data_s),
        .done  (done_s)
    );

    assign spi.ss   = ss_r;
    assign spi.sclk = sclk_s;
    assign spi.mosi = 1'b0;

    assign x_new_s = {x_hi_r, x_lo_r};
    assign y_new_s = {y_hi_r, y_lo_r};

    assign jstkPos        = pos_r;
    assign jstkPress      = press_r;
    assign jstkPressPulse = press_pulse_r;
    assign x_raw          = x_raw_r;
    assign y_raw          = y_raw_r;
    assign sample_valid   = sample_valid_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state, byte start and counter clear
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        cnt_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cnt_r == 32'(POLL_CYCLES - 1)) begin
                    state_next_s = ST_SETUP;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 32'(PRE_GAP - 1)) begin
                    state_next_s = ST_SHIFT;
                    start_s      = 1'b1;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (done_s) begin
                    if (idx_r == 3'd4) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (cnt_r == 32'(BYTE_GAP - 1)) begin
                    state_next_s = ST_SHIFT;
                    start_s      = 1'b1;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                cnt_clr_s    = 1'b1;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // Shared wait counter: poll period, pre-gap and inter-byte gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 32'd0;
        end else if (cnt_clr_s) begin
            cnt_r <= 32'd0;
        end else if ((state_r == ST_IDLE) || (state_r == ST_SETUP) || (state_r == ST_GAP)) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= 32'd0;
        end
    end

    // Byte index within the transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= 3'd0;
        end else if ((state_r == ST_GAP) && cnt_clr_s) begin
            idx_r <= idx_r + 3'd1;
        end else if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            idx_r <= 3'd0;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Capture the useful bits of each received byte; reset discards partials
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_lo_r <= 8'd0;
            x_hi_r <= 2'd0;
            y_lo_r <= 8'd0;
            y_hi_r <= 2'd0;
            btn_r  <= 1'b0;
        end else if ((state_r == ST_SHIFT) && done_s) begin
            case (idx_r)
                3'd0:    x_lo_r <= data_s;
                3'd1:    x_hi_r <= data_s[1:0];
                3'd2:    y_lo_r <= data_s;
                3'd3:    y_hi_r <= data_s[1:0];
                3'd4:    btn_r  <= data_s[0];
                default: btn_r  <= btn_r;
            endcase
        end else begin
            btn_r <= btn_r;
        end
    end

    // Chip select: high in IDLE, so it rises on the edge that ends DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_r <= 1'b1;
        end else begin
            ss_r <= (state_next_s == ST_IDLE);
        end
    end

    // Decode and publish results on the edge that ends DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_r          <= 4'b0000;
            press_r        <= 1'b0;
            press_pulse_r  <= 1'b0;
            x_raw_r        <= AXIS_CENTER;
            y_raw_r        <= AXIS_CENTER;
            sample_valid_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            pos_r          <= decode_pos(x_new_s, y_new_s, LOW_TH, HIGH_TH);
            press_r        <= btn_r;
            press_pulse_r  <= btn_r & ~press_r;
            x_raw_r        <= x_new_s;
            y_raw_r        <= y_new_s;
            sample_valid_r <= 1'b1;
        end else begin
            press_pulse_r  <= 1'b0;
            sample_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jstk_reader.sv
module tb_jstk_reader;

    localparam int P_CH   = 4;
    localparam int P_PRE  = 20;
    localparam int P_BG   = 10;
    localparam int P_POLL = 200;
    localparam int TXN_LEN = P_PRE + 80 * P_CH + 4 * P_BG + 1;
    localparam int WAIT_MAX = 2000;

    typedef struct packed {
        logic [3:0] pos;
        logic       press;
        logic       pulse;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic clk;
    logic rst;
    logic [3:0] jstkPos;
    logic jstkPress;
    logic jstkPressPulse;
    logic [9:0] x_raw;
    logic [9:0] y_raw;
    logic sample_valid;

    jstk_reader_if spi_bus();

    jstk_reader #(
        .CLK_HALF    (P_CH),
        .PRE_GAP     (P_PRE),
        .BYTE_GAP    (P_BG),
        .POLL_CYCLES (P_POLL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spi            (spi_bus),
        .jstkPos        (jstkPos),
        .jstkPress      (jstkPress),
        .jstkPressPulse (jstkPressPulse),
        .x_raw          (x_raw),
        .y_raw          (y_raw),
        .sample_valid   (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    obs_t exp_q[$];
    logic model_press;
    logic [39:0] frame;

    // bus monitor / slave model state
    logic ss_prev, sclk_prev;
    int ptr;
    int low_len, low_len_last;
    int hi_len, hi_len_last;
    int first_rise, first_rise_last;
    int rises, rises_last;
    int mosi_hi;
    int falls_seen;
    int pulse_total, pulse_no_sv;

    function automatic logic [3:0] model_pos(input int x, input int y);
        logic [3:0] p;
        p[3] = (y > 768);
        p[2] = (y < 256);
        p[1] = (x < 256);
        p[0] = (x > 768);
        return p;
    endfunction

    task automatic load_txn(input logic [9:0] x, input logic [9:0] y, input logic b, input bit expect_it);
        frame = {x[7:0], 6'b101101, x[9:8], y[7:0], 6'b010011, y[9:8], 7'b1100110, b};
        if (expect_it) begin
            exp_q.push_back({model_pos(int'(x), int'(y)), b, b & ~model_press, x, y});
            model_press = b;
        end
    endtask

    task automatic wait_sample(output obs_t o, output bit got, output int sv_len, output int pulse_len);
        got = 1'b0;
        o = '0;
        sv_len = 0;
        pulse_len = 0;
        for (int i = 0; i < WAIT_MAX && !got; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                got = 1'b1;
                o = {jstkPos, jstkPress, jstkPressPulse, x_raw, y_raw};
            end
        end
        if (got) begin
            sv_len = 1;
            pulse_len = int'(jstkPressPulse);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                sv_len += int'(sample_valid);
                pulse_len += int'(jstkPressPulse);
            end
        end
    endtask

    // SPI slave model and bus monitor, evaluated away from the active edge
    initial begin
        spi_bus.miso = 1'b0;
        ss_prev = 1'b1; sclk_prev = 1'b0; ptr = 0;
        low_len = 0; low_len_last = 0; hi_len = 0; hi_len_last = 0;
        first_rise = -1; first_rise_last = -1; rises = 0; rises_last = 0;
        mosi_hi = 0; falls_seen = 0; pulse_total = 0; pulse_no_sv = 0;
        forever begin
            @(negedge clk);
            if (spi_bus.mosi !== 1'b0) mosi_hi++;
            if (jstkPressPulse === 1'b1) begin
                pulse_total++;
                if (sample_valid !== 1'b1) pulse_no_sv++;
            end
            if (!rst) begin
                ss_prev = 1'b1; sclk_prev = 1'b0; ptr = 0; rises = 0;
                hi_len = 0; spi_bus.miso = 1'b0;
            end else begin
                if (ss_prev && !spi_bus.ss) begin
                    hi_len_last = hi_len;
                    low_len = 1; first_rise = -1; rises = 0; ptr = 0;
                    falls_seen++;
                    spi_bus.miso = frame[39];
                end else if (!ss_prev && spi_bus.ss) begin
                    low_len_last = low_len; rises_last = rises;
                    first_rise_last = first_rise; hi_len = 1;
                end else if (!spi_bus.ss) begin
                    low_len++;
                end else begin
                    hi_len++;
                end
                if (!spi_bus.ss && spi_bus.sclk && !sclk_prev) begin
                    rises++;
                    if (first_rise < 0) first_rise = low_len - 1;
                end
                if (!spi_bus.ss && !spi_bus.sclk && sclk_prev) begin
                    ptr++;
                    spi_bus.miso = (ptr < 40) ? frame[39 - ptr] : 1'b0;
                end
                ss_prev = spi_bus.ss;
                sclk_prev = spi_bus.sclk;
            end
        end
    end

    task automatic test_reset;
        int n;
        repeat (3) @(negedge clk);
        checks++; if (spi_bus.ss !== 1'b1) begin fails++; $display("FAIL reset_ss: got %b want 1", spi_bus.ss); end
        checks++; if (spi_bus.sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", spi_bus.sclk); end
        checks++; if (spi_bus.mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", spi_bus.mosi); end
        checks++; if (jstkPos !== 4'b0000) begin fails++; $display("FAIL reset_pos: got %b want 0000", jstkPos); end
        checks++; if (jstkPress !== 1'b0) begin fails++; $display("FAIL reset_press: got %b want 0", jstkPress); end
        checks++; if (jstkPressPulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", jstkPressPulse); end
        checks++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        checks++; if (x_raw !== 10'd512) begin fails++; $display("FAIL reset_x: got %0d want 512", x_raw); end
        checks++; if (y_raw !== 10'd512) begin fails++; $display("FAIL reset_y: got %0d want 512", y_raw); end
        load_txn(10'd900, 10'd512, 1'b0, 1'b1);
        rst = 1'b1;
        n = -1;
        for (int i = 1; i <= P_POLL + 50 && n < 0; i++) begin
            @(negedge clk);
            if (spi_bus.ss === 1'b0) n = i;
        end
        checks++;
        if (n != P_POLL) begin fails++; $display("FAIL first_ss_fall: got %0d cycles want %0d", n, P_POLL); end
    endtask

    task automatic test_right;
        obs_t o, e; bit got; int svl, pl;
        wait_sample(o, got, svl, pl);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin fails++; $display("FAIL right_timeout: got no sample_valid want 1 pulse"); end
        else begin
            if (o !== e) begin fails++; $display("FAIL right_out: got pos=%b pr=%b pu=%b x=%0d y=%0d want pos=%b pr=%b pu=%b x=%0d y=%0d", o.pos, o.press, o.pulse, o.x, o.y, e.pos, e.press, e.pulse, e.x, e.y); end
            checks++; if (svl != 1) begin fails++; $display("FAIL right_valid_len: got %0d want 1", svl); end
            checks++; if (pl != 0) begin fails++; $display("FAIL right_pulse: got %0d want 0", pl); end
        end
    endtask

    task automatic test_protocol;
        int f0; bit seen;
        checks++; if (low_len_last != TXN_LEN) begin fails++; $display("FAIL ss_low_len: got %0d want %0d", low_len_last, TXN_LEN); end
        checks++; if (first_rise_last != P_PRE + P_CH) begin fails++; $display("FAIL first_rise: got %0d want %0d", first_rise_last, P_PRE + P_CH); end
        checks++; if (rises_last != 40) begin fails++; $display("FAIL sclk_rises: got %0d want 40", rises_last); end
        checks++; if (mosi_hi != 0) begin fails++; $display("FAIL mosi_zero: got %0d nonzero cycles want 0", mosi_hi); end
        load_txn(10'd100, 10'd1000, 1'b1, 1'b1);
        f0 = falls_seen; seen = 1'b0;
        for (int i = 0; i < WAIT_MAX && !seen; i++) begin
            @(negedge clk);
            if (falls_seen != f0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin fails++; $display("FAIL poll_gap_timeout: got no ss fall want one"); end
        else if (hi_len_last != P_POLL) begin fails++; $display("FAIL poll_gap: got %0d want %0d", hi_len_last, P_POLL); end
    endtask

    task automatic test_press;
        obs_t o, e; bit got; int svl, pl;
        for (int k = 0; k < 2; k++) begin
            wait_sample(o, got, svl, pl);
            e = exp_q.pop_front();
            if (k == 0) load_txn(10'd100, 10'd1000, 1'b1, 1'b1);
            checks++;
            if (!got) begin fails++; $display("FAIL press_timeout[%0d]: got no sample_valid want 1 pulse", k); end
            else begin
                if (o !== e) begin fails++; $display("FAIL press_out[%0d]: got pos=%b pr=%b pu=%b x=%0d y=%0d want pos=%b pr=%b pu=%b x=%0d y=%0d", k, o.pos, o.press, o.pulse, o.x, o.y, e.pos, e.press, e.pulse, e.x, e.y); end
                checks++; if (pl != ((k == 0) ? 1 : 0)) begin fails++; $display("FAIL press_pulse_len[%0d]: got %0d want %0d", k, pl, (k == 0) ? 1 : 0); end
            end
        end
    endtask

    task automatic test_boundaries;
        logic [9:0] bx[4];
        logic [9:0] by[4];
        obs_t o, e; bit got; int svl, pl;
        bx[0] = 10'd768; by[0] = 10'd256;
        bx[1] = 10'd769; by[1] = 10'd255;
        bx[2] = 10'd256; by[2] = 10'd768;
        bx[3] = 10'd255; by[3] = 10'd769;
        for (int k = 0; k < 4; k++) begin
            load_txn(bx[k], by[k], 1'b0, 1'b1);
            wait_sample(o, got, svl, pl);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin fails++; $display("FAIL bound_timeout[%0d]: got no sample_valid want 1 pulse", k); end
            else if (o !== e) begin fails++; $display("FAIL bound_out[%0d]: got pos=%b x=%0d y=%0d want pos=%b x=%0d y=%0d", k, o.pos, o.x, o.y, e.pos, e.x, e.y); end
        end
    endtask

    task automatic test_reset_mid;
        obs_t o, e; bit got; int svl, pl; bit hit;
        load_txn(10'd1000, 10'd50, 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < WAIT_MAX && !hit; i++) begin
            @(negedge clk);
            if (spi_bus.ss === 1'b0 && rises >= 20) hit = 1'b1;
        end
        checks++;
        if (!hit) begin fails++; $display("FAIL midrst_reach: got no byte 2 activity want some"); end
        #1 rst = 1'b0;
        #1;
        checks++; if (spi_bus.ss !== 1'b1) begin fails++; $display("FAIL midrst_ss: got %b want 1", spi_bus.ss); end
        checks++; if (spi_bus.sclk !== 1'b0) begin fails++; $display("FAIL midrst_sclk: got %b want 0", spi_bus.sclk); end
        checks++;
        if ({jstkPos, jstkPress, jstkPressPulse, sample_valid, x_raw, y_raw} !== {4'b0000, 1'b0, 1'b0, 1'b0, 10'd512, 10'd512}) begin
            fails++; $display("FAIL midrst_outputs: got pos=%b pr=%b x=%0d y=%0d want pos=0000 pr=0 x=512 y=512", jstkPos, jstkPress, x_raw, y_raw);
        end
        repeat (3) @(negedge clk);
        exp_q.delete();
        model_press = 1'b0;
        load_txn(10'd600, 10'd100, 1'b0, 1'b1);
        rst = 1'b1;
        wait_sample(o, got, svl, pl);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin fails++; $display("FAIL midrst_after_timeout: got no sample_valid want 1 pulse"); end
        else if (o !== e) begin fails++; $display("FAIL midrst_after: got pos=%b pr=%b x=%0d y=%0d want pos=%b pr=%b x=%0d y=%0d", o.pos, o.press, o.x, o.y, e.pos, e.press, e.x, e.y); end
    endtask

    task automatic test_button_toggle;
        obs_t o, e; bit got; int svl, pl; int p0, n0;
        logic seq[4];
        seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0; seq[3] = 1'b1;
        p0 = pulse_total; n0 = pulse_no_sv;
        for (int k = 0; k < 4; k++) begin
            load_txn(10'd512, 10'd512, seq[k], 1'b1);
            wait_sample(o, got, svl, pl);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin fails++; $display("FAIL toggle_timeout[%0d]: got no sample_valid want 1 pulse", k); end
            else if (o !== e) begin fails++; $display("FAIL toggle_out[%0d]: got pr=%b pu=%b pos=%b want pr=%b pu=%b pos=%b", k, o.press, o.pulse, o.pos, e.press, e.pulse, e.pos); end
        end
        checks++; if (pulse_total - p0 != 2) begin fails++; $display("FAIL toggle_pulses: got %0d want 2", pulse_total - p0); end
        checks++; if (pulse_no_sv - n0 != 0) begin fails++; $display("FAIL toggle_coincident: got %0d stray pulses want 0", pulse_no_sv - n0); end
    endtask

    initial begin
        rst = 1'b0;
        model_press = 1'b0;
        frame = 40'd0;
        test_reset;
        test_right;
        test_protocol;
        test_press;
        test_boundaries;
        test_reset_mid;
        test_button_toggle;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/jstk_reader.md
# jstk_reader

Upstream input stage for the game: polls the PmodJSTK joystick over SPI, decodes the 10-bit X/Y axes and the stick button, and presents `jstkPos` (up, down, left, right) and `jstkPress` in the exact form the game manager and player manager consume. It runs autonomously on the system clock, one 5-byte transaction per poll period. Outputs change only at the end of a completed transaction.

## Interface

Parameters:
- `CLK_HALF`, 100: clk cycles per SCLK half-period (500 kHz at 100 MHz).
- `PRE_GAP`, 1500: cycles between SS falling and the first SCLK edge (15 µs).
- `BYTE_GAP`, 1000: idle cycles between bytes, SS held low (10 µs).
- `POLL_CYCLES`, 1_000_000: cycles from transaction end to next start (10 ms).
- `LOW_TH`, 10'd256; `HIGH_TH`, 10'd768: axis thresholds.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `miso` in 1: SPI data from joystick.
- `ss` out 1: SPI chip select, active-low.
- `sclk` out 1: SPI clock, idle low.
- `mosi` out 1: SPI data to joystick; constant 0.
- `jstkPos` out 4: {up, down, left, right}, level.
- `jstkPress` out 1: stick button, level.
- `jstkPressPulse` out 1: one-cycle pulse on a 0→1 change of `jstkPress`.
- `x_raw` out 10, `y_raw` out 10: last decoded axes, for LED debug.
- `sample_valid` out 1: one-cycle pulse when outputs update.

## Operation

- FSM states: IDLE, SETUP, SHIFT, GAP, DONE.
- IDLE: `ss`=1. Poll counter increments. At `POLL_CYCLES`-1 → SETUP, counter clears.
- SETUP: `ss`=0. Waits `PRE_GAP` cycles → SHIFT with byte index 0.
- SHIFT: SPI mode 0, MSB first. `sclk` toggles every `CLK_HALF` cycles. `miso` is sampled into the shift register on each rising `sclk` edge. After the 8th falling edge, the byte is stored in buf[idx]. If idx<4 → GAP. If idx=4 → DONE.
- GAP: `sclk`=0. Waits `BYTE_GAP` cycles, increments idx, → SHIFT.
- DONE, one cycle: `ss`=1. Decode and register outputs, pulse `sample_valid` → IDLE.
- Byte map:
  - buf0 = X[7:0]; buf1[1:0] = X[9:8].
  - buf2 = Y[7:0]; buf3[1:0] = Y[9:8].
  - buf4[0] = stick button. Other bits are ignored.
- Decode uses strict compares:
  - up = Y>HIGH_TH; down = Y<LOW_TH.
  - right = X>HIGH_TH; left = X<LOW_TH.
  - Up/down are mutually exclusive by construction, as are left/right. Diagonals assert one bit from each pair.
- `jstkPressPulse` = new button AND NOT previous registered `jstkPress`, asserted in the DONE cycle.

## Timing

- Reset values:
  - `ss`=1, `sclk`=0, `mosi`=0.
  - `jstkPos`=4'b0000, `jstkPress`=0, `jstkPressPulse`=0, `sample_valid`=0.
  - `x_raw`=`y_raw`=10'd512.
  - FSM in IDLE, poll counter and idx at 0.
- Reset asserted mid-transaction aborts immediately: `ss` rises asynchronously and partial bytes are discarded. The first transaction starts `POLL_CYCLES` cycles after reset release.
- Transaction length = PRE_GAP + 5·16·CLK_HALF + 4·BYTE_GAP + 1 = 13501 cycles at defaults.
- Output latency: outputs are valid on the clk edge ending DONE, one cycle after the 40th falling `sclk` edge.
- Outputs are stable between `sample_valid` pulses. Consumers sample them as levels.
- X=HIGH_TH or X=LOW_TH exactly produces no direction bit for that axis.

## Structure

- Shared package `jstk_pkg`:
  - Bit indices UP=3, DOWN=2, LEFT=1, RIGHT=0.
  - FSM state encoding.
  - Default thresholds and reset center 10'd512.
- Sub-module `spi_byte_shifter`:
  - Mode-0 single-byte engine: start, `CLK_HALF` parameter, `sclk`, `miso` in.
  - Outputs: 8-bit data and a done pulse.
  - The `jstk_reader` FSM sequences five bytes through it.

## Test plan

- SPI slave model returns X=900, Y=512, button=0 → after one transaction `jstkPos`=4'b0001, `x_raw`=900, `sample_valid` pulses once, `jstkPressPulse`=0.
- X=100, Y=1000, button=1 → `jstkPos`=4'b1010, `jstkPress`=1, `jstkPressPulse` high exactly one cycle. A repeat with the same data gives no further pulse.
- X=768, Y=256 (boundaries) → `jstkPos`=4'b0000. X=769, Y=255 → 4'b0101.
- Protocol check on the bus:
  - `ss` low for exactly 13501 cycles.
  - First `sclk` rise PRE_GAP+CLK_HALF cycles after `ss` fall.
  - 40 rising edges total, `mosi` always 0.
  - Next `ss` fall POLL_CYCLES cycles after `ss` rise.
- Assert `rst` low during byte 2 → `ss`=1 and `sclk`=0 within the same cycle, outputs return to reset values. After release, the first full transaction decodes correctly with no stale bytes.
- Button toggles 0→1→0→1 over four transactions → exactly two `jstkPressPulse` pulses, each coincident with `sample_valid`.
